// File: rtl/history_serializer_if.sv
// Output beat stream of the history serializer: data/last qualified by valid,
// with downstream ready flowing back.
interface history_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready_in;

    modport master (output out_data, output out_valid, output out_last, input out_ready_in);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready_in);
endinterface

// File: rtl/history_serializer.sv
// Snapshots the four tracker history entries on request and replays the
// valid-prefix entries one per beat on a valid/ready stream.
module history_serializer #(
    parameter int DATA_W       = 8,
    parameter bit OLDEST_FIRST = 1'b0
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [DATA_W-1:0]     hist_0_in,
    input  logic [DATA_W-1:0]     hist_1_in,
    input  logic [DATA_W-1:0]     hist_2_in,
    input  logic [DATA_W-1:0]     hist_3_in,
    input  logic                  hist_valid_0_in,
    input  logic                  hist_valid_1_in,
    input  logic                  hist_valid_2_in,
    input  logic                  hist_valid_3_in,
    input  logic                  snap_req_in,
    history_serializer_if.master  out_if,
    output logic                  busy,
    output logic                  snap_empty,
    output logic                  snap_drop
);
    typedef enum logic {IDLE, SEND} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] hist_w   [4];
    logic [DATA_W-1:0] shadow_q [4];
    logic [2:0]        count_q;
    logic [1:0]        idx_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              snap_empty_q;
    logic              snap_drop_q;

    logic [2:0]        req_count;
    logic [1:0]        first_idx;
    logic [1:0]        next_idx;
    logic [1:0]        last_idx;

    assign hist_w[0] = hist_0_in;
    assign hist_w[1] = hist_1_in;
    assign hist_w[2] = hist_2_in;
    assign hist_w[3] = hist_3_in;

    // Count only the unbroken run of valid flags starting at the newest entry.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        req_count = 3'd0;
        if (hist_valid_0_in) begin
            req_count = 3'd1;
            if (hist_valid_1_in) begin
                req_count = 3'd2;
                if (hist_valid_2_in) begin
                    req_count = hist_valid_3_in ? 3'd4 : 3'd3;
                end
            end
        end
        first_idx = OLDEST_FIRST ? 2'(req_count - 3'd1) : 2'd0;
        next_idx  = OLDEST_FIRST ? idx_q - 2'd1 : idx_q + 2'd1;
        last_idx  = OLDEST_FIRST ? 2'd0 : 2'(count_q - 3'd1);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= IDLE;
            count_q      <= 3'd0;
            idx_q        <= 2'd0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            snap_empty_q <= 1'b0;
            snap_drop_q  <= 1'b0;
            // NOTE: the shadow is only four words, so it is reset too and never holds stale data after reset.
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
        end else begin
            snap_empty_q <= 1'b0;
            snap_drop_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (snap_req_in) begin
                        for (int i = 0; i < 4; i++) shadow_q[i] <= hist_w[i];
                        count_q <= req_count;
                        if (req_count == 3'd0) begin
                            snap_empty_q <= 1'b1;
                        end else begin
                            state_q     <= SEND;
                            idx_q       <= first_idx;
                            out_valid_q <= 1'b1;
                            out_data_q  <= hist_w[first_idx];
                            out_last_q  <= (req_count == 3'd1);
                        end
                    end
                end
                SEND: begin
                    if (snap_req_in) snap_drop_q <= 1'b1;
                    if (out_if.out_ready_in) begin
                        if (idx_q == last_idx) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            idx_q      <= next_idx;
                            out_data_q <= shadow_q[next_idx];
                            out_last_q <= (next_idx == last_idx);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_last  = out_last_q;
    assign busy             = (state_q == SEND);
    assign snap_empty       = snap_empty_q;
    assign snap_drop        = snap_drop_q;
endmodule

// File: tb/tb_history_serializer.sv
// Scoreboard bench: two serializers (newest-first and oldest-first) share one
// stimulus stream; a reference model queues expected beats, a monitor checks them.
module tb_history_serializer;
    localparam int DATA_W = 8;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk      = 1'b0;
    logic              reset_in = 1'b1;
    logic              snap_req = 1'b0;
    logic              ready    = 1'b0;
    logic [DATA_W-1:0] hist [4];
    logic [3:0]        hv       = 4'h0;

    logic [1:0]        busy_w, empty_w, drop_w, v_w, l_w;
    logic [DATA_W-1:0] d_w [2];

    history_serializer_if #(.DATA_W(DATA_W)) sif0 ();
    history_serializer_if #(.DATA_W(DATA_W)) sif1 ();

    assign sif0.out_ready_in = ready;
    assign sif1.out_ready_in = ready;
    assign v_w = {sif1.out_valid, sif0.out_valid};
    assign l_w = {sif1.out_last, sif0.out_last};
    assign d_w[0] = sif0.out_data;
    assign d_w[1] = sif1.out_data;

    history_serializer #(.DATA_W(DATA_W), .OLDEST_FIRST(1'b0)) dut_newest (
        .clk_in(clk), .reset_in(reset_in),
        .hist_0_in(hist[0]), .hist_1_in(hist[1]), .hist_2_in(hist[2]), .hist_3_in(hist[3]),
        .hist_valid_0_in(hv[0]), .hist_valid_1_in(hv[1]),
        .hist_valid_2_in(hv[2]), .hist_valid_3_in(hv[3]),
        .snap_req_in(snap_req), .out_if(sif0),
        .busy(busy_w[0]), .snap_empty(empty_w[0]), .snap_drop(drop_w[0])
    );

    history_serializer #(.DATA_W(DATA_W), .OLDEST_FIRST(1'b1)) dut_oldest (
        .clk_in(clk), .reset_in(reset_in),
        .hist_0_in(hist[0]), .hist_1_in(hist[1]), .hist_2_in(hist[2]), .hist_3_in(hist[3]),
        .hist_valid_0_in(hv[0]), .hist_valid_1_in(hv[1]),
        .hist_valid_2_in(hv[2]), .hist_valid_3_in(hv[3]),
        .snap_req_in(snap_req), .out_if(sif1),
        .busy(busy_w[1]), .snap_empty(empty_w[1]), .snap_drop(drop_w[1])
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    int    pending   [2];
    logic  exp_empty [2];
    logic  exp_drop  [2];
    beat_t exp_q     [2][$];

    task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, d, got, exp, $time);
        end
    endtask

    // Reference model: a snapshot is the list of valid-prefix entries, in send order.
    initial begin
        for (int d = 0; d < 2; d++) begin
            pending[d] = 0;
            exp_empty[d] = 1'b0;
            exp_drop[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (reset_in) begin
                    pending[d] = 0;
                    exp_q[d].delete();
                    exp_empty[d] = 1'b0;
                    exp_drop[d] = 1'b0;
                end else begin
                    bit was_busy;
                    was_busy = (pending[d] > 0);
                    exp_empty[d] = 1'b0;
                    exp_drop[d] = 1'b0;
                    if (was_busy && ready) pending[d]--;
                    if (snap_req) begin
                        if (was_busy) begin
                            exp_drop[d] = 1'b1;
                        end else begin
                            int n;
                            n = 0;
                            while (n < 4 && hv[n]) n++;
                            if (n == 0) begin
                                exp_empty[d] = 1'b1;
                            end else begin
                                pending[d] = n;
                                for (int k = 0; k < n; k++) begin
                                    beat_t b;
                                    b.data = hist[(d == 1) ? n - 1 - k : k];
                                    b.last = (k == n - 1);
                                    exp_q[d].push_back(b);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Monitor: retire the head beat on every handshake.
    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 2; d++)
            if (v_w[d] && ready && exp_q[d].size() > 0) void'(exp_q[d].pop_front());
    end

    // Monitor: compare presented outputs against the scoreboard mid-cycle.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("out_valid", d, v_w[d], pending[d] > 0);
            check("busy", d, busy_w[d], pending[d] > 0);
            check("snap_empty", d, empty_w[d], exp_empty[d]);
            check("snap_drop", d, drop_w[d], exp_drop[d]);
            if (v_w[d]) begin
                if (exp_q[d].size() > 0) begin
                    check("out_data", d, d_w[d], exp_q[d][0].data);
                    check("out_last", d, l_w[d], exp_q[d][0].last);
                end else begin
                    check("unexpected_beat", d, 1, 0);
                end
            end else begin
                check("idle_data", d, d_w[d], 0);
                check("idle_last", d, l_w[d], 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hist(input logic [7:0] h0, h1, h2, h3, input logic [3:0] v);
        hist[0] = h0; hist[1] = h1; hist[2] = h2; hist[3] = h3;
        hv = v;
    endtask

    task automatic req_pulse();
        snap_req = 1'b1;
        step(1);
        snap_req = 1'b0;
    endtask

    initial begin
        int rs [7];
        rs = '{0, 0, 1, 0, 1, 1, 1};
        set_hist(8'd3, 8'd4, 8'd2, 8'd1, 4'hF);

        // Reset hold with request and ready asserted.
        reset_in = 1'b1; snap_req = 1'b1; ready = 1'b1;
        step(3);
        reset_in = 1'b0; snap_req = 1'b0;
        step(3);

        // Full snapshot, streaming.
        req_pulse();
        step(6);

        // Partial snapshots: valid prefix of two, then a broken prefix of one.
        set_hist(8'd2, 8'd1, 8'd0, 8'd0, 4'b0011);
        req_pulse();
        step(4);
        set_hist(8'd2, 8'd1, 8'd0, 8'd0, 4'b0101);
        req_pulse();
        step(3);

        // Backpressure, with history changing mid-drain.
        set_hist(8'd3, 8'd4, 8'd2, 8'd1, 4'hF);
        req_pulse();
        for (int i = 0; i < 7; i++) begin
            ready = rs[i][0];
            if (i == 1) set_hist(8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'hF);
            step(1);
        end
        ready = 1'b1;
        step(4);

        // Empty request.
        set_hist(8'd9, 8'd8, 8'd7, 8'd6, 4'h0);
        req_pulse();
        step(3);

        // Drop during SEND, then drop at the last-beat edge and accept on the next.
        set_hist(8'd3, 8'd4, 8'd2, 8'd1, 4'hF);
        req_pulse();
        step(1);
        req_pulse();
        step(1);
        snap_req = 1'b1;
        step(2);
        snap_req = 1'b0;
        step(6);

        // Reset after the second of four beats.
        req_pulse();
        step(2);
        reset_in = 1'b1;
        step(1);
        reset_in = 1'b0;
        step(5);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            reset_in = ($urandom_range(0, 49) == 0);
            snap_req = ($urandom_range(0, 3) == 0);
            ready    = ($urandom_range(0, 2) != 0);
            hv       = 4'($urandom);
            for (int k = 0; k < 4; k++) hist[k] = 8'($urandom);
            step(1);
        end
        reset_in = 1'b0; snap_req = 1'b0; ready = 1'b1;
        step(8);

        for (int d = 0; d < 2; d++) check("drained", d, exp_q[d].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/history_serializer.md
# history_serializer

Reader side of the last-distinct-values tracker: on request it snapshots the tracker's four history outputs and their valid flags, then replays the valid entries one per beat on a valid/ready stream. It sits between the tracker and any downstream consumer (UART framer, debug FIFO) that needs the history as a serial sequence. Snapshot and serialization are decoupled, so the tracker keeps running while a snapshot drains.

## Interface
Parameters:
- DATA_W, 8, width of each history entry and of the output beat
- OLDEST_FIRST, 0, send order: 0 = entry 0 (newest) first; 1 = highest valid entry (oldest) first

Ports:
- clk_in  input  1  single clock, all logic on rising edge
- reset_in  input  1  synchronous, active-high reset, minimum 1 cycle
- hist_0_in .. hist_3_in  input  DATA_W each  tracker history; 0 = newest, 3 = oldest
- hist_valid_0_in .. hist_valid_3_in  input  1 each  tracker valid flags
- snap_req_in  input  1  snapshot request, sampled every cycle
- out_ready_in  input  1  downstream ready
- out_data  output  DATA_W  current beat data
- out_valid  output  1  beat valid
- out_last  output  1  final beat of the snapshot, qualified by out_valid
- busy  output  1  snapshot held and draining
- snap_empty  output  1  one-cycle pulse: request accepted but no valid entries
- snap_drop  output  1  one-cycle pulse: request arrived while busy and was ignored

## Operation
- States: IDLE, SEND.
- IDLE, snap_req_in=1 at an edge: copy hist_*_in into shadow registers; compute count = number of consecutive valid flags starting at index 0 (valid_0..valid_k all 1). A set flag after the first clear flag is ignored.
- count = 0: stay in IDLE; snap_empty = 1 for the next cycle; no beat is sent.
- count 1..4: go to SEND; beat index = 0 (OLDEST_FIRST=0) or count-1 (OLDEST_FIRST=1).
- SEND: out_valid=1, out_data = shadow[index], out_last=1 when this is the final beat (index = count-1, or index = 0 when OLDEST_FIRST=1).
- Handshake: a beat transfers at an edge where out_valid & out_ready_in. out_data and out_last are held stable while out_valid & !out_ready_in. On transfer, index steps +1 (or -1 when OLDEST_FIRST=1). A transfer of the last beat returns to IDLE.
- snap_req_in=1 in SEND: ignored; shadow untouched; snap_drop=1 for the next cycle. A request at the same edge as the last-beat transfer is also dropped. A new request is accepted only in IDLE.
- Shadow values do not track hist_*_in after capture.
- Outputs idle-zero: when out_valid=0, out_data=0 and out_last=0.
- busy = 1 exactly when the state is SEND.
- Count uses 3 bits; index uses 2 bits; no wrap is possible because SEND exits on the last beat.

## Timing
- Reset: while reset_in is high, all outputs are 0 at every edge: out_data=0, out_valid=0, out_last=0, busy=0, snap_empty=0, snap_drop=0. Shadow=0, state=IDLE.
- Reset during SEND aborts the snapshot. No further beat is sent after release.
- Reset has priority over a same-cycle snap_req_in.
- Latency: request sampled at edge N gives out_valid=1 and the first beat during cycle N+1, with busy=1 from cycle N+1.
- With out_ready_in held at 1, beats stream back-to-back, one per cycle. A snapshot of count n occupies cycles N+1..N+n. busy and out_valid fall in cycle N+n+1.
- A request at edge N+n+1 (first IDLE edge) is accepted, so the minimum gap between snapshots is 1 idle cycle.
- snap_empty and snap_drop are high in cycle N+1 only.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset hold: reset_in=1 for 3 cycles with snap_req_in=1, out_ready_in=1 -> all outputs 0 throughout; no beat after release until a new request.
- Full snapshot, OLDEST_FIRST=0: hist = 3,4,2,1, all valid; req for 1 cycle; ready=1 -> beats 3,4,2,1 on consecutive cycles starting 1 cycle after the request; out_last only on 1; busy for 4 cycles.
- Partial snapshot, OLDEST_FIRST=1: hist = 2,1,0,0, valid = 1,1,0,0 -> beats 1 then 2, out_last on 2. Repeat with valid = 1,0,1,0 -> single beat 2 with out_last.
- Backpressure: full snapshot 3,4,2,1; ready toggles 0,0,1,0,1,1,1 -> out_data holds 3 for 3 cycles, then 4 for 2 cycles; order 3,4,2,1 intact; hist inputs changed mid-drain do not affect the beats.
- Empty and drop: req with all valid=0 -> snap_empty pulse for 1 cycle, out_valid stays 0. Req during SEND -> snap_drop pulse, current sequence unchanged. Req at the last-beat edge is dropped; req on the next edge is accepted.
- Reset mid-drain: reset_in=1 after the 2nd beat of 4 -> outputs 0 on the next edge; after release, no residual beats.
